alu_mdu: RTL and testbench

//  Parametrised execution unit that supersedes the single-cycle ALU. It adds shifts and XOR,

---
 rtl/alu_mdu_if.sv | 27 ++
 rtl/alu_mdu.sv | 171 +++++++++++++++++
 tb/tb_alu_mdu.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_if.sv
// Handshake and data bundle between the EX-stage issue logic and the alu_mdu execution unit.
interface alu_mdu_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 4
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] aluout;
  logic                  zero;
  logic                  busy;

  modport master (
    output flush, in_valid, op1, op2, ctrl, out_ready,
    input  in_ready, out_valid, aluout, zero, busy
  );

  modport slave (
    input  flush, in_valid, op1, op2, ctrl, out_ready,
    output in_ready, out_valid, aluout, zero, busy
  );
endinterface

// File: rtl/alu_mdu.sv
// EX-stage execution unit: single-cycle ALU ops plus iterative shift-add multiply and
// restoring divide behind a valid/ready handshake, with a registered result and zero flag.
module alu_mdu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_mdu_if.slave  bus
);
  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned ShW  = $clog2(DATA_WIDTH);
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  localparam logic [CTRL_WIDTH-1:0] OpAdd   = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] OpSub   = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] OpAnd   = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] OpOr    = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] OpXor   = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] OpSlt   = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] OpSltu  = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] OpSll   = CTRL_WIDTH'(7);
  localparam logic [CTRL_WIDTH-1:0] OpSrl   = CTRL_WIDTH'(8);
  localparam logic [CTRL_WIDTH-1:0] OpSra   = CTRL_WIDTH'(9);
  localparam logic [CTRL_WIDTH-1:0] OpMul   = CTRL_WIDTH'(10);
  localparam logic [CTRL_WIDTH-1:0] OpMulhu = CTRL_WIDTH'(11);
  localparam logic [CTRL_WIDTH-1:0] OpDivu  = CTRL_WIDTH'(12);
  localparam logic [CTRL_WIDTH-1:0] OpRemu  = CTRL_WIDTH'(13);
  localparam logic [CTRL_WIDTH-1:0] OpDiv   = CTRL_WIDTH'(14);
  localparam logic [CTRL_WIDTH-1:0] OpRem   = CTRL_WIDTH'(15);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [W-1:0]          acc_q, lo_q, opb_q, aluout_q;
  logic                  zero_q, negq_q, negr_q;
  logic [CTRL_WIDTH-1:0] op_q;

  logic [W-1:0]   a, b, a_abs, b_abs, fast_res;
  logic [ShW-1:0] shamt;
  logic           is_mul, is_div, is_sdiv, is_rem, div_zero, ovf, start_div, accept;

  assign a        = bus.op1;
  assign b        = bus.op2;
  assign shamt    = b[ShW-1:0];
  assign is_mul   = (bus.ctrl == OpMul) | (bus.ctrl == OpMulhu);
  assign is_sdiv  = (bus.ctrl == OpDiv) | (bus.ctrl == OpRem);
  assign is_div   = (bus.ctrl == OpDivu) | (bus.ctrl == OpRemu) | is_sdiv;
  assign is_rem   = (bus.ctrl == OpRemu) | (bus.ctrl == OpRem);
  assign div_zero = (b == '0);
  assign ovf      = is_sdiv & (a == {1'b1, {(W-1){1'b0}}}) & (b == '1);
  assign start_div = is_div & ~div_zero & ~ovf;
  assign a_abs    = (is_sdiv & a[W-1]) ? -a : a;
  assign b_abs    = (is_sdiv & b[W-1]) ? -b : b;

  assign bus.in_ready = rst_n & ~bus.flush &
                        ((state_q == StIdle) | ((state_q == StDone) & bus.out_ready));
  assign accept       = bus.in_valid & bus.in_ready;

  // Divide special cases (by zero, signed overflow) resolve here in a single cycle.
  always_comb begin
    fast_res = '0;
    case (bus.ctrl)
      OpAdd:   fast_res = a + b;
      OpSub:   fast_res = a - b;
      OpAnd:   fast_res = a & b;
      OpOr:    fast_res = a | b;
      OpXor:   fast_res = a ^ b;
      OpSlt:   fast_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu:  fast_res = {{(W-1){1'b0}}, a < b};
      OpSll:   fast_res = a << shamt;
      OpSrl:   fast_res = a >> shamt;
      OpSra:   fast_res = $unsigned($signed(a) >>> shamt);
      default: begin
        if (is_rem) fast_res = ovf ? '0 : a;
        else        fast_res = div_zero ? '1 : a;
      end
    endcase
  end

  logic [W:0]   mul_sum, div_sh, div_diff;
  logic [W-1:0] mul_hi, mul_lo, div_rem, div_quo, mul_res, div_res;
  logic         div_ge, last;

  assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign mul_hi   = mul_sum[W:1];
  assign mul_lo   = {mul_sum[0], lo_q[W-1:1]};
  assign mul_res  = (op_q == OpMul) ? mul_lo : mul_hi;
  assign div_sh   = {acc_q, lo_q[W-1]};
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_ge   = ~div_diff[W];
  assign div_rem  = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
  assign div_quo  = {lo_q[W-2:0], div_ge};
  assign div_res  = ((op_q == OpRemu) | (op_q == OpRem)) ? (negr_q ? -div_rem : div_rem)
                                                         : (negq_q ? -div_quo : div_quo);
  assign last     = (cnt_q == CntW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      aluout_q <= '0;
      zero_q   <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      op_q     <= '0;
    end else if (bus.flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            op_q  <= bus.ctrl;
            cnt_q <= '0;
            if (is_mul) begin
              acc_q   <= '0;
              lo_q    <= a;
              opb_q   <= b;
              state_q <= StMul;
            end else if (start_div) begin
              acc_q   <= '0;
              lo_q    <= a_abs;
              opb_q   <= b_abs;
              negq_q  <= is_sdiv & (a[W-1] ^ b[W-1]);
              negr_q  <= is_sdiv & a[W-1];
              state_q <= StDiv;
            end else begin
              aluout_q <= fast_res;
              zero_q   <= (fast_res == '0);
              state_q  <= StDone;
            end
          end else if (state_q == StDone && bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        StMul: begin
          acc_q <= mul_hi;
          lo_q  <= mul_lo;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            aluout_q <= mul_res;
            zero_q   <= (mul_res == '0);
            cnt_q    <= '0;
            state_q  <= StDone;
          end
        end
        StDiv: begin
          acc_q <= div_rem;
          lo_q  <= div_quo;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            aluout_q <= div_res;
            zero_q   <= (div_res == '0);
            cnt_q    <= '0;
            state_q  <= StDone;
          end
        end
      endcase
    end
  end

  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StMul) | (state_q == StDiv);
  assign bus.aluout    = aluout_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: results are predicted at accept time into a queue and
// compared by a monitor when the unit hands them over.
module tb_alu_mdu;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic [31:0] exp_q[$];

  alu_mdu_if #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) bus ();

  alu_mdu #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    p  = {32'h0, a} * {32'h0, b};
    sa = a;
    sb = b;
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return {31'b0, sa < sb};
      4'd6:  return {31'b0, a < b};
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return $unsigned(sa >>> b[4:0]);
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      4'd13: if (b == 0) return a; else return a % b;
      4'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $unsigned(sa / sb);
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $unsigned(sa % sb);
      end
    endcase
  endfunction

  // Scoreboard side: a result is consumed at the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got %h, required no result", bus.aluout);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.aluout !== e) begin
          n_fail++;
          $display("FAIL result_value: got %h, required %h", bus.aluout, e);
        end
        n_tests++;
        if (bus.zero !== (e == 32'h0)) begin
          n_fail++;
          $display("FAIL result_zero: got %b, required %b (value %h)", bus.zero, e == 0, e);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.ctrl     = c;
    bus.op1      = a;
    bus.op2      = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        exp_q.push_back(model(c, a, b));
        done = 1;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready=0 for 200 cycles, required accept (op %0d)", c);
    end
  endtask

  // Counts negedges without out_valid after an accept, and how many of them showed busy.
  task automatic measure(output int lat, output int busy_cnt);
    bit seen = 0;
    lat = 0;
    busy_cnt = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
      else begin
        lat++;
        if (bus.busy) busy_cnt++;
      end
    end
    if (!seen) lat = -1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.out_valid) ok = 1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op1 = '0; bus.op2 = '0; bus.ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.zero, bus.aluout} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b zero=%b out=%h, required all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.zero, bus.aluout);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b vld=%b, required rdy=1 vld=0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_basic;
    int t0;
    bit ok;
    bus.out_ready = 1'b1;
    t0 = cyc;
    issue(4'd0, 32'hFFFF_FFFF, 32'h1);
    issue(4'd1, 32'd5, 32'd5);
    n_tests++;
    if (cyc - t0 != 2) begin
      n_fail++;
      $display("FAIL basic_throughput: got %0d cycles, required 2", cyc - t0);
    end
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_second_valid: got vld=%b rdy=%b, required 1 1",
               bus.out_valid, bus.in_ready);
    end
    drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL basic_drain: got pending, required empty"); end
  endtask

  task automatic test_mul;
    int lat, bc;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      issue(k == 0 ? 4'd10 : 4'd11, 32'h0001_0000, 32'h0001_0000);
      measure(lat, bc);
      n_tests++;
      if (lat != 32 || bc != 32) begin
        n_fail++;
        $display("FAIL mul_latency: got lat=%0d busy=%0d, required 32 32", lat, bc);
      end
    end
  endtask

  task automatic test_div;
    logic [3:0]  ops[4] = '{4'd14, 4'd15, 4'd12, 4'd13};
    logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
    int lat, bc;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue(ops[k], as[k], bs[k]);
      measure(lat, bc);
      n_tests++;
      if (lat != 32) begin
        n_fail++;
        $display("FAIL div_latency: got %0d, required 32 (op %0d)", lat, ops[k]);
      end
    end
  endtask

  task automatic test_div_special;
    logic [3:0]  ops[4] = '{4'd12, 4'd15, 4'd14, 4'd15};
    logic [31:0] as[4]  = '{32'd9, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int lat, bc;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue(ops[k], as[k], bs[k]);
      measure(lat, bc);
      n_tests++;
      if (lat != 0 || bc != 0) begin
        n_fail++;
        $display("FAIL divspecial_latency: got %0d busy=%0d, required 0 0 (op %0d)",
                 lat, bc, ops[k]);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    bus.out_ready = 1'b0;
    issue(4'd9, 32'h8000_0000, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.aluout !== 32'hF800_0000 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold: got vld=%b out=%h rdy=%b, required 1 f8000000 0",
                 bus.out_valid, bus.aluout, bus.in_ready);
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL backpressure_drain: got pending, required empty"); end
  endtask

  task automatic test_back_to_back;
    int t0;
    bit ok;
    logic [31:0] a, b;
    bus.out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) issue(4'($urandom_range(9)), $urandom, $urandom);
    n_tests++;
    if (cyc - t0 != 10) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d cycles, required 10", cyc - t0);
    end
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(20));
        default: b = $urandom;
      endcase
      issue(4'($urandom_range(15)), a, b);
    end
    drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_drain: got pending, required empty"); end
  endtask

  task automatic test_flush_reset;
    bit seen = 0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.ctrl = 4'd12; bus.op1 = 32'd100; bus.op2 = 32'd7;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
      @(posedge clk);
    end
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: got vld=%b busy=%b rdy=%b, required 0 0 1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
    // Flush while idle with a valid op: nothing may be accepted.
    @(posedge clk);
    #1;
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.ctrl = 4'd0;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: got %b, required 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL flush_no_result: got out_valid=1, required 0"); end
    @(posedge clk);
    #1;
    issue(4'd0, 32'd1, 32'd2);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1; bus.ctrl = 4'd10; bus.op1 = 32'd3; bus.op2 = 32'd5;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.aluout !== 32'd3) begin
      n_fail++;
      $display("FAIL mul_inflight: got busy=%b out=%h, required 1 00000003", bus.busy, bus.aluout);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.zero, bus.aluout} !== 36'h0) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b vld=%b busy=%b zero=%b out=%h, required all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.zero, bus.aluout);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_recover: got in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_mul();
    test_div();
    test_div_special();
    test_backpressure();
    test_back_to_back();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end
endmodule
